led_pulse_multi: RTL and testbench

- Multi-channel successor to the single-LED pulse generator.
- Drives `Channels` LED outputs from one shared PWM counter and one shared duty counter.
- Each channel has a runtime-selectable mode (OFF / ON / PULSE / BLINK) and a phase offset, so several LEDs can breathe or blink in staggered patterns.
- Sits beside the status/housekeeping logic and is configured through a simple single-cycle write port.

---
 rtl/led_pulse_multi.sv | 146 ++++++++++++++
 tb/tb_led_pulse_multi.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pulse_multi.sv
// led_pulse_multi: drives Channels LEDs (OFF/ON/PULSE/BLINK) from one shared PWM counter and duty counter.
// Build macro LED_PULSE_GAMMA_EN squares the PULSE triangle for a perceptually smoother breathe.
module led_pulse_multi #(
    parameter int                 Channels = 4,
    parameter int                 ChanBits = 2,
    parameter int                 PWMBits  = 8,
    parameter logic [PWMBits-1:0] PWMMax   = 8'hFF,
    parameter int                 DutyBits = 6,
    parameter logic               OnBit    = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                cfg_wr,
    input  logic [ChanBits-1:0] cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [DutyBits:0]   cfg_phase,
    output logic [Channels-1:0] led,
    output logic                tick
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_PULSE = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    localparam logic [PWMBits-1:0]  PwmZero  = {PWMBits{1'b0}};
    localparam logic [PWMBits-1:0]  PwmOne   = {{(PWMBits-1){1'b0}}, 1'b1};
    localparam logic [DutyBits:0]   DutyZero = {(DutyBits+1){1'b0}};
    localparam logic [DutyBits:0]   DutyOne  = {{DutyBits{1'b0}}, 1'b1};
    localparam logic [DutyBits:0]   DutyMax  = {(DutyBits+1){1'b1}};
    localparam logic [Channels-1:0] LedOff   = {Channels{~OnBit}};

    function automatic logic [DutyBits-1:0] bit_rev(input logic [DutyBits-1:0] v);
        logic [DutyBits-1:0] o;
        for (int k = 0; k < DutyBits; k++) begin
            o[k] = v[DutyBits-1-k];
        end
        return o;
    endfunction

    logic [PWMBits-1:0]  pwm_r;
    logic [DutyBits:0]   duty_r;
    logic [Channels-1:0] led_r;
    logic                tick_r;
    logic                wrap_s;
    logic [DutyBits-1:0] r_s;
    logic [Channels-1:0] drive_s;

    assign wrap_s = enable && (pwm_r == PWMMax);
    // Bit-reversing the top PWM bits spreads each duty's on-time across the period.
    assign r_s    = bit_rev(pwm_r[PWMBits-1 -: DutyBits]);

    // Shared PWM and duty counters; both freeze while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_r  <= PwmZero;
            duty_r <= DutyZero;
        end else if (enable) begin
            if (wrap_s) begin
                pwm_r  <= PwmZero;
                duty_r <= duty_r + DutyOne;
            end else begin
                pwm_r  <= pwm_r + PwmOne;
            end
        end
    end

    for (genvar g = 0; g < Channels; g++) begin : g_chan
        mode_e               shadow_mode_r;
        mode_e               active_mode_r;
        logic [DutyBits:0]   shadow_phase_r;
        logic [DutyBits:0]   active_phase_r;
        logic                wr_sel_s;
        logic [DutyBits:0]   e_s;
        logic [DutyBits-1:0] a_s;
        logic [DutyBits-1:0] lvl_s;
        logic                lit_s;

        // Channel indices >= Channels have no block here, so writes to them are dropped.
        assign wr_sel_s = cfg_wr && (cfg_chan == ChanBits'(g));
        assign e_s      = duty_r + active_phase_r;
        assign a_s      = e_s[DutyBits] ? ~e_s[DutyBits-1:0] : e_s[DutyBits-1:0];

`ifdef LED_PULSE_GAMMA_EN
        logic [2*DutyBits-1:0] sq_s;
        assign sq_s  = {{DutyBits{1'b0}}, a_s} * {{DutyBits{1'b0}}, a_s};
        assign lvl_s = sq_s[2*DutyBits-1:DutyBits];
`else
        assign lvl_s = a_s;
`endif

        // Shadow takes every write; active reloads only at wrap, with same-cycle writes bypassing.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                shadow_mode_r  <= MODE_OFF;
                shadow_phase_r <= DutyZero;
                active_mode_r  <= MODE_OFF;
                active_phase_r <= DutyZero;
            end else begin
                if (wr_sel_s) begin
                    shadow_mode_r  <= mode_e'(cfg_mode);
                    shadow_phase_r <= cfg_phase;
                end
                if (wrap_s) begin
                    active_mode_r  <= wr_sel_s ? mode_e'(cfg_mode) : shadow_mode_r;
                    active_phase_r <= wr_sel_s ? cfg_phase : shadow_phase_r;
                end
            end
        end

        // Per-channel lit decision from the active mode.
        always_comb begin
            lit_s = 1'b0;
            case (active_mode_r)
                MODE_OFF:   lit_s = 1'b0;
                MODE_ON:    lit_s = 1'b1;
                MODE_PULSE: lit_s = (r_s < lvl_s);
                MODE_BLINK: lit_s = ~e_s[DutyBits];
                default:    lit_s = 1'b0;
            endcase
        end

        assign drive_s[g] = lit_s ? OnBit : ~OnBit;
    end

    // Registered LED drive and wrap tick; disabling blanks the LEDs on the next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_r  <= LedOff;
            tick_r <= 1'b0;
        end else if (!enable) begin
            led_r  <= LedOff;
            tick_r <= 1'b0;
        end else begin
            led_r  <= drive_s;
            tick_r <= wrap_s && (duty_r == DutyMax);
        end
    end

    assign led  = led_r;
    assign tick = tick_r;

endmodule

// File: tb/tb_led_pulse_multi.sv
// Self-checking bench for led_pulse_multi (4 channels, 16-cycle PWM, 8-step duty, active-low LEDs).
// Compile with LED_PULSE_GAMMA_EN defined to check the squared PULSE curve.
module tb_led_pulse_multi;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       cfg_wr;
    logic [1:0] cfg_chan;
    logic [1:0] cfg_mode;
    logic [2:0] cfg_phase;
    logic [3:0] led;
    logic       tick;

    led_pulse_multi #(
        .Channels(4),
        .ChanBits(2),
        .PWMBits (4),
        .PWMMax  (4'd15),
        .DutyBits(2),
        .OnBit   (1'b0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .cfg_wr   (cfg_wr),
        .cfg_chan (cfg_chan),
        .cfg_mode (cfg_mode),
        .cfg_phase(cfg_phase),
        .led      (led),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  chan;
        logic [1:0]  mode;
        logic [2:0]  phase;
        logic [39:0] exp_low;   // eight 5-bit lit counts, duty 0 in the top field
    } vec_t;

    vec_t vecs [7];
    int   exp_q [$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cnt   = 0;   // enabled clock edges since reset release
    int   edges = 0;   // all clock edges

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edges++;
        if (reset_n && enable) cnt++;
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [1:0] md, input logic [2:0] ph);
        cfg_wr    = 1'b1;
        cfg_chan  = ch;
        cfg_mode  = md;
        cfg_phase = ph;
        step();
        cfg_wr    = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, bad, lows, expv, e0, guard, hits;
        logic [1:0] ch;

        vecs[0] = '{chan: 2'd0, mode: 2'd0, phase: 3'd0,
                    exp_low: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}};
        vecs[3] = '{chan: 2'd1, mode: 2'd3, phase: 3'd0,
                    exp_low: {5'd16, 5'd16, 5'd16, 5'd16, 5'd0, 5'd0, 5'd0, 5'd0}};
        vecs[5] = '{chan: 2'd1, mode: 2'd3, phase: 3'd2,
                    exp_low: {5'd16, 5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 5'd16, 5'd16}};
        vecs[6] = '{chan: 2'd0, mode: 2'd1, phase: 3'd0,
                    exp_low: {5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16, 5'd16}};
`ifdef LED_PULSE_GAMMA_EN
        vecs[1] = '{chan: 2'd2, mode: 2'd2, phase: 3'd0,
                    exp_low: {5'd0, 5'd0, 5'd4, 5'd8, 5'd8, 5'd4, 5'd0, 5'd0}};
        vecs[2] = '{chan: 2'd3, mode: 2'd2, phase: 3'd4,
                    exp_low: {5'd8, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd8}};
        vecs[4] = '{chan: 2'd2, mode: 2'd2, phase: 3'd6,
                    exp_low: {5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd8, 5'd8, 5'd4}};
`else
        vecs[1] = '{chan: 2'd2, mode: 2'd2, phase: 3'd0,
                    exp_low: {5'd0, 5'd4, 5'd8, 5'd12, 5'd12, 5'd8, 5'd4, 5'd0}};
        vecs[2] = '{chan: 2'd3, mode: 2'd2, phase: 3'd4,
                    exp_low: {5'd12, 5'd8, 5'd4, 5'd0, 5'd0, 5'd4, 5'd8, 5'd12}};
        vecs[4] = '{chan: 2'd2, mode: 2'd2, phase: 3'd6,
                    exp_low: {5'd4, 5'd0, 5'd0, 5'd4, 5'd8, 5'd12, 5'd12, 5'd8}};
`endif

        reset_n   = 1'b0;
        enable    = 1'b0;
        cfg_wr    = 1'b0;
        cfg_chan  = 2'd0;
        cfg_mode  = 2'd0;
        cfg_phase = 3'd0;
        repeat (2) step();
        check("reset_led", led, 4'hF);
        check("reset_tick", tick, 1'b0);

        reset_n = 1'b1;
        enable  = 1'b1;
        cnt     = 0;
        bad     = 0;
        repeat (20) begin
            step();
            if (led !== 4'hF) bad++;
        end
        check("post_reset_all_off", bad, 0);

        // Shadow write mid-period, then a bypass write landing exactly on the wrap edge.
        while (cnt % 16 != 5) step();
        base = cnt - 5;
        cfg_write(2'd0, 2'd1, 3'd0);
        cfg_write(2'd1, 2'd0, 3'd0);
        bad = 0;
        while (cnt != base + 16) begin
            step();
            if (led[1] !== 1'b1) bad++;
        end
        check("on_before_wrap", led[0], 1'b1);
        step();
        check("on_after_wrap", led[0], 1'b0);
        while (cnt % 16 != 15) begin
            step();
            if (led[1] !== 1'b1) bad++;
        end
        cfg_write(2'd0, 2'd0, 3'd0);
        check("bypass_pre", led[0], 1'b0);
        step();
        check("bypass_post", led[0], 1'b1);
        check("ch1_off_steady", bad, 0);

        // Table: configure one channel, then count lit cycles per PWM period over a full pulse.
        for (int v = 0; v < 7; v++) begin
            ch = vecs[v].chan;
            cfg_write(vecs[v].chan, vecs[v].mode, vecs[v].phase);
            while (cnt % 128 != 0) step();
            for (int k = 0; k < 8; k++) exp_q.push_back(int'(vecs[v].exp_low[(7-k)*5 +: 5]));
            for (int w = 0; w < 8; w++) begin
                lows = 0;
                for (int s = 0; s < 16; s++) begin
                    step();
                    if (led[ch] === 1'b0) lows++;
                end
                expv = exp_q.pop_front();
                check($sformatf("vec%0d_duty%0d_lit", v, w), lows, expv);
            end
        end

        // Free run: tick must appear only when the state is duty 0, pwm 0.
        bad  = 0;
        hits = 0;
        repeat (256) begin
            step();
            if (tick === 1'b1) hits++;
            if (tick !== ((cnt % 128) == 0)) bad++;
        end
        check("tick_position", bad, 0);
        check("tick_count", hits, 2);

        // Disable mid-period for 40 cycles; everything resumes from the frozen count.
        while (cnt % 128 != 70) step();
        e0     = edges;
        enable = 1'b0;
        bad    = 0;
        hits   = 0;
        repeat (40) begin
            step();
            if (led !== 4'hF) bad++;
            if (tick !== 1'b0) hits++;
        end
        check("disabled_led", bad, 0);
        check("disabled_tick", hits, 0);
        enable = 1'b1;
        step();
        check("reenable_led0", led[0], 1'b0);
        check("reenable_led1_frozen", led[1], 1'b1);
        guard = 0;
        while (tick !== 1'b1 && guard < 300) begin
            step();
            guard++;
        end
        check("tick_delay", edges, e0 + 58 + 40);

        // Asynchronous reset mid-cycle while outputs are active.
        while (cnt % 128 != 0) step();
        check("pre_reset_tick", tick, 1'b1);
        check("pre_reset_led0", led[0], 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_led", led, 4'hF);
        check("async_reset_tick", tick, 1'b0);
        repeat (2) step();
        reset_n = 1'b1;
        cnt     = 0;
        bad     = 0;
        repeat (40) begin
            step();
            if (led !== 4'hF) bad++;
        end
        check("config_lost", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
